// File: rtl/perf_mon_pkg.sv
// Shared types and default widths for the stream performance monitor.
// Optional stall/starve counters are enabled with PERF_MON_STALL_EN.
package perf_mon_pkg;

  localparam int unsigned PM_DATA_W = 64;
  localparam int unsigned PM_CNT_W  = 32;

  typedef enum logic [1:0] {
    PM_IDLE = 2'd0,
    PM_RUN  = 2'd1,
    PM_DONE = 2'd2
  } pm_state_e;

endpackage

// File: rtl/perf_sat_cnt.sv
// Saturating event counter: clr beats load1 beats inc.
// Holds at all-ones instead of wrapping.
module perf_sat_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = {W{1'b1}};
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= ONE;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/stream_perf_monitor.sv
// Zero-latency AXI-Stream probe measuring beats and cycles up to a limit.
// Define PERF_MON_STALL_EN to build the stall/starve counters.
module stream_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int unsigned DATA_W = PM_DATA_W,
  parameter int unsigned CNT_W  = PM_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [CNT_W-1:0]  cnt_limit,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [CNT_W-1:0]  data_cnt,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  starve_cnt,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] LIM_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   NXT_ONE = {{CNT_W{1'b0}}, 1'b1};

  pm_state_e        state_q;
  pm_state_e        state_d;
  logic [CNT_W-1:0] lim_q;
  logic [CNT_W:0]   data_nxt;
  logic             beat;
  logic             idle;
  logic             run;
  logic             arm;
  logic             hit;

  assign m_axis_tvalid = s_axis_tvalid;
  assign m_axis_tdata  = s_axis_tdata;
  assign s_axis_tready = m_axis_tready;

  assign beat = s_axis_tvalid && m_axis_tready;
  assign idle = (state_q == PM_IDLE);
  assign run  = (state_q == PM_RUN);
  assign arm  = idle && beat && enable && !clear;

  // One bit wider so a saturated count or a zero limit can never match.
  assign data_nxt = {1'b0, data_cnt} + NXT_ONE;
  assign hit      = run && beat && (data_nxt == {1'b0, lim_q});

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PM_IDLE: begin
        if (arm) begin
          state_d = (cnt_limit == LIM_ONE) ? PM_DONE : PM_RUN;
        end
      end
      PM_RUN: begin
        if (hit) begin
          state_d = PM_DONE;
        end
      end
      PM_DONE: state_d = PM_DONE;
      default: state_d = PM_IDLE;
    endcase
    if (clear) begin
      state_d = PM_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lim_q <= '0;
    end else if (arm) begin
      lim_q <= cnt_limit;
    end
  end

  assign busy = run;
  assign done = (state_q == PM_DONE);

  perf_sat_cnt #(.W(CNT_W)) u_data_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .load1   (arm),
    .inc     (run && beat),
    .cnt     (data_cnt)
  );

  perf_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .load1   (arm),
    .inc     (run),
    .cnt     (cycle_cnt)
  );

`ifdef PERF_MON_STALL_EN
  perf_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .load1   (1'b0),
    .inc     (run && s_axis_tvalid && !m_axis_tready),
    .cnt     (stall_cnt)
  );

  perf_sat_cnt #(.W(CNT_W)) u_starve_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .load1   (1'b0),
    .inc     (run && !s_axis_tvalid && m_axis_tready),
    .cnt     (starve_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign starve_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_perf_monitor.sv
// Bench for stream_perf_monitor: directed cases plus random traffic
// against a rule-level model, on a 32-bit and a 4-bit counter instance.
module tb_stream_perf_monitor;

  localparam int DW = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          clear;
  logic          s_tvalid;
  logic          m_tready;
  logic [CW-1:0] cnt_limit;
  logic [3:0]    lim4;
  logic [DW-1:0] s_tdata;

  logic          s_tready, m_tvalid, busy, done;
  logic [DW-1:0] m_tdata;
  logic [CW-1:0] data_cnt, cycle_cnt, stall_cnt, starve_cnt;

  logic          s_tready4, m_tvalid4, busy4, done4;
  logic [7:0]    m_tdata4;
  logic [3:0]    data4, cycle4, stall4, starve4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stream_perf_monitor #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .clear         (clear),
    .cnt_limit     (cnt_limit),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .data_cnt      (data_cnt),
    .cycle_cnt     (cycle_cnt),
    .stall_cnt     (stall_cnt),
    .starve_cnt    (starve_cnt),
    .busy          (busy),
    .done          (done)
  );

  stream_perf_monitor #(.DATA_W(8), .CNT_W(4)) dut4 (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .clear         (clear),
    .cnt_limit     (lim4),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready4),
    .s_axis_tdata  (s_tdata[7:0]),
    .m_axis_tvalid (m_tvalid4),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata4),
    .data_cnt      (data4),
    .cycle_cnt     (cycle4),
    .stall_cnt     (stall4),
    .starve_cnt    (starve4),
    .busy          (busy4),
    .done          (done4)
  );

  // Reference model: one entry per instance, plain integer arithmetic.
  longint md[2], mc[2], ms[2], mv[2], ml[2];
  bit     mrun[2], mdone[2];
  longint mmax[2] = '{64'hFFFF_FFFF, 64'd15};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint x, input int i);
    return (x > mmax[i]) ? mmax[i] : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      md[i] = 0; mc[i] = 0; ms[i] = 0; mv[i] = 0; ml[i] = 0;
      mrun[i] = 0; mdone[i] = 0;
    end
  endtask

  task automatic model_step();
    bit     b;
    longint lim_in;
    longint nd;
    b = s_tvalid && m_tready;
    for (int i = 0; i < 2; i++) begin
      lim_in = (i == 0) ? longint'(cnt_limit) : longint'(lim4);
      if (clear) begin
        md[i] = 0; mc[i] = 0; ms[i] = 0; mv[i] = 0;
        mrun[i] = 0; mdone[i] = 0;
      end else if (mdone[i]) begin
        // finished measurement is frozen until cleared
      end else if (!mrun[i]) begin
        if (b && enable) begin
          ml[i] = lim_in;
          md[i] = 1;
          mc[i] = 1;
          if (lim_in == 1) mdone[i] = 1;
          else mrun[i] = 1;
        end
      end else begin
        mc[i] = sat(mc[i] + 1, i);
        if (s_tvalid && !m_tready) ms[i] = sat(ms[i] + 1, i);
        if (!s_tvalid && m_tready) mv[i] = sat(mv[i] + 1, i);
        if (b) begin
          nd = md[i] + 1;
          md[i] = sat(nd, i);
          if (ml[i] != 0 && nd == ml[i]) begin
            mrun[i] = 0;
            mdone[i] = 1;
          end
        end
      end
    end
  endtask

  function automatic longint exp_opt(input longint v);
`ifdef PERF_MON_STALL_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check_outs();
    chk("data_cnt", data_cnt, md[0]);
    chk("cycle_cnt", cycle_cnt, mc[0]);
    chk("stall_cnt", stall_cnt, exp_opt(ms[0]));
    chk("starve_cnt", starve_cnt, exp_opt(mv[0]));
    chk("busy", busy, mrun[0]);
    chk("done", done, mdone[0]);
    chk("data4", data4, md[1]);
    chk("cycle4", cycle4, mc[1]);
    chk("stall4", stall4, exp_opt(ms[1]));
    chk("starve4", starve4, exp_opt(mv[1]));
    chk("busy4", busy4, mrun[1]);
    chk("done4", done4, mdone[1]);
  endtask

  task automatic cycle(input bit v, input bit r, input bit en,
                       input bit clr, input logic [CW-1:0] lim,
                       input logic [3:0] l4);
    @(negedge clk);
    s_tvalid  = v;
    m_tready  = r;
    enable    = en;
    clear     = clr;
    cnt_limit = lim;
    lim4      = l4;
    s_tdata   = {$urandom, $urandom};
    #1;
    chk("pt_tdata", m_tdata, s_tdata);
    chk("pt_tvalid", m_tvalid, s_tvalid);
    chk("pt_tready", s_tready, m_tready);
    chk("pt_tdata4", m_tdata4, s_tdata[7:0]);
    chk("pt_tvalid4", m_tvalid4, s_tvalid);
    chk("pt_tready4", s_tready4, m_tready);
    model_step();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    clear     = 1'b0;
    s_tvalid  = 1'b0;
    m_tready  = 1'b0;
    cnt_limit = '0;
    lim4      = '0;
    s_tdata   = '0;
    model_reset();
    #12;
    chk("rst_data", data_cnt, 0);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    check_outs();
    @(negedge clk);
    reset_n = 1'b1;

    // limit 4, back-to-back beats
    for (int k = 0; k < 4; k++) begin
      if (k == 3) chk("l4_not_done_yet", done, 0);
      cycle(1, 1, 1, 0, 4, 4);
    end
    chk("l4_done", done, 1);
    chk("l4_data", data_cnt, 4);
    chk("l4_cycle", cycle_cnt, 4);
    chk("l4_stall", stall_cnt, 0);
    chk("l4_done4", done4, 1);
    cycle(0, 0, 0, 1, 0, 0);
    chk("clr_data", data_cnt, 0);

    // limit 4 with two backpressure cycles between beats 2 and 3
    cycle(1, 1, 1, 0, 4, 4);
    cycle(1, 1, 0, 0, 4, 4);
    cycle(1, 0, 0, 0, 4, 4);
    cycle(1, 0, 0, 0, 4, 4);
    cycle(1, 1, 0, 0, 4, 4);
    cycle(1, 1, 0, 0, 4, 4);
    chk("bp_cycle", cycle_cnt, 6);
    chk("bp_data", data_cnt, 4);
`ifdef PERF_MON_STALL_EN
    chk("bp_stall", stall_cnt, 2);
`else
    chk("bp_stall", stall_cnt, 0);
`endif
    chk("bp_done", done, 1);
    cycle(0, 0, 0, 1, 0, 0);

    // limit 1: straight to DONE, then frozen
    cycle(1, 1, 1, 0, 1, 1);
    chk("l1_done", done, 1);
    chk("l1_busy", busy, 0);
    chk("l1_data", data_cnt, 1);
    chk("l1_cycle", cycle_cnt, 1);
    for (int k = 0; k < 3; k++) cycle(1, 1, 1, 0, 7, 7);
    chk("l1_hold_data", data_cnt, 1);
    chk("l1_hold_cycle", cycle_cnt, 1);
    chk("l1_hold_done", done, 1);
    cycle(0, 0, 0, 1, 0, 0);

    // free-running; 4-bit instance saturates
    for (int k = 0; k < 20; k++) cycle(1, 1, 1, 0, 0, 0);
    chk("fr_busy4", busy4, 1);
    chk("fr_data4", data4, 15);
    chk("fr_cycle4", cycle4, 15);
    chk("fr_done4", done4, 0);
    chk("fr_data", data_cnt, 20);

    // clear coincident with a beat, in RUN and in IDLE
    cycle(1, 1, 0, 1, 0, 0);
    chk("cb_data", data_cnt, 0);
    chk("cb_cycle", cycle_cnt, 0);
    chk("cb_busy", busy, 0);
    cycle(1, 1, 1, 1, 3, 3);
    chk("ci_busy", busy, 0);
    chk("ci_data", data_cnt, 0);

    // asynchronous reset in the middle of a run
    cycle(1, 1, 1, 0, 9, 9);
    cycle(1, 1, 0, 0, 9, 9);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("ar_data", data_cnt, 0);
    chk("ar_cycle", cycle_cnt, 0);
    chk("ar_busy", busy, 0);
    check_outs();
    @(negedge clk);
    reset_n = 1'b1;

    // random traffic
    for (int k = 0; k < 800; k++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0,
            CW'($urandom_range(0, 6)), 4'($urandom_range(0, 6)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
